// File: rtl/yas_router_pkg.sv
// Shared constants for the router output path: FSM encoding, header layout, channel count.
package yas_router_pkg;

  localparam int unsigned NUM_CH = 3;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StHdr  = 2'd1;
  localparam logic [1:0] StPay  = 2'd2;

  // Header byte layout: address in the low two bits, payload length above it.
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned LEN_LSB  = 2;

  function automatic logic [1:0] oh_to_idx(input logic [NUM_CH-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter_3.sv
// Combinational 3-way round-robin pick; search starts one past the last granted channel.
module rr_arbiter_3 import yas_router_pkg::*; (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [1:0]        last_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic              valid_o
);

  always_comb begin
    gnt_o = '0;
    unique case (last_i)
      2'd0: begin
        if      (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
      end
      2'd1: begin
        if      (req_i[2]) gnt_o = 3'b100;
        else if (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
      end
      default: begin
        if      (req_i[0]) gnt_o = 3'b001;
        else if (req_i[1]) gnt_o = 3'b010;
        else if (req_i[2]) gnt_o = 3'b100;
      end
    endcase
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/yas_out_arbiter.sv
// Packet-aware round-robin merge of three channel streams onto one link, with a payload
// stall watchdog and a completed-packet counter.
module yas_out_arbiter import yas_router_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 6,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_req,
  output logic [NUM_CH-1:0]            ch_ack,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [1:0]                   out_ch,
  output logic                         out_req,
  input  logic                         out_ack,
  output logic                         abort,
  output logic [15:0]                  pkt_cnt
);

  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);

  logic [1:0]            state_q, state_d;
  logic [1:0]            grant_q, grant_d;
  logic [1:0]            last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WdWidth-1:0]    wd_q, wd_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d;
  logic                  abort_q, abort_d;

  logic [NUM_CH-1:0]     pick_oh;
  logic                  pick_valid;
  logic [NUM_CH-1:0]     grant_oh;
  logic [DATA_WIDTH-1:0] data_g;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic                  req_g;
  logic                  active;
  logic                  xfer;

  rr_arbiter_3 u_rr (
    .req_i   (ch_req),
    .last_i  (last_grant_q),
    .gnt_o   (pick_oh),
    .valid_o (pick_valid)
  );

  assign grant_oh = NUM_CH'(1) << grant_q;
  assign req_g    = |(ch_req & grant_oh);
  assign active   = (state_q == StHdr) || (state_q == StPay);
  assign xfer     = out_req && out_ack;
  assign hdr_len  = data_g[LEN_LSB +: LEN_WIDTH];

  always_comb begin
    data_g = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == 2'(i)) data_g = ch_data[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    pkt_cnt_d    = pkt_cnt_q;
    abort_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        wd_d = '0;
        if (pick_valid) begin
          grant_d = oh_to_idx(pick_oh);
          state_d = StHdr;
        end
      end
      StHdr: begin
        if (xfer) begin
          cnt_d = hdr_len;
          if (hdr_len == '0) begin
            state_d      = StIdle;
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
            last_grant_d = grant_q;
          end else begin
            state_d = StPay;
          end
        end
      end
      StPay: begin
        wd_d = req_g ? '0 : wd_q + WdWidth'(1);
        if (xfer) begin
          cnt_d = cnt_q - LEN_WIDTH'(1);
          if (cnt_q == LEN_WIDTH'(1)) begin
            state_d      = StIdle;
            pkt_cnt_d    = pkt_cnt_q + 16'd1;
            last_grant_d = grant_q;
          end
        end else if (!req_g && (wd_q == WdWidth'(TIMEOUT - 1))) begin
          // Remaining bytes of the dropped packet are left for the channel to flush.
          state_d      = StIdle;
          abort_d      = 1'b1;
          wd_d         = '0;
          last_grant_d = grant_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      cnt_q        <= '0;
      wd_q         <= '0;
      pkt_cnt_q    <= '0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      pkt_cnt_q    <= pkt_cnt_d;
      abort_q      <= abort_d;
    end
  end

  assign out_req  = active && req_g;
  assign out_data = active ? data_g : '0;
  assign ch_ack   = xfer ? grant_oh : '0;
  assign out_ch   = grant_q;
  assign abort    = abort_q;
  assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_yas_out_arbiter.sv
// Directed bench for yas_out_arbiter: queue-backed channel sources, transfer log, inline checks.
module tb_yas_out_arbiter;

  logic        clk;
  logic        rst_n;
  logic [23:0] ch_data;
  logic [2:0]  ch_req;
  logic [2:0]  ch_ack;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_req;
  logic        out_ack;
  logic        abort;
  logic [15:0] pkt_cnt;

  yas_out_arbiter #(
    .DATA_WIDTH (8),
    .LEN_WIDTH  (6),
    .TIMEOUT    (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_data  (ch_data),
    .ch_req   (ch_req),
    .ch_ack   (ch_ack),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .abort    (abort),
    .pkt_cnt  (pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int abort_seen = 0;
  logic ack_toggle = 1'b0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [9:0] log_q[$];
  int         log_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive();
    ch_req = 3'b000;
    ch_data = '0;
    if (q0.size() != 0) begin ch_req[0] = 1'b1; ch_data[7:0]   = q0[0]; end
    if (q1.size() != 0) begin ch_req[1] = 1'b1; ch_data[15:8]  = q1[0]; end
    if (q2.size() != 0) begin ch_req[2] = 1'b1; ch_data[23:16] = q2[0]; end
  endtask

  // One clock: sample handshake mid-cycle, cross the edge, pop consumed bytes, settle.
  task automatic tick();
    logic [2:0] acked;
    drive();
    #1;
    acked = ch_ack;
    if (out_req && out_ack) begin
      log_q.push_back({out_ch, out_data});
      log_t.push_back(cyc);
    end
    if (abort === 1'b1) abort_seen++;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (acked[0] && q0.size() != 0) void'(q0.pop_front());
    if (acked[1] && q1.size() != 0) void'(q1.pop_front());
    if (acked[2] && q2.size() != 0) void'(q2.pop_front());
    if (ack_toggle) out_ack = ~out_ack;
    drive();
    #1;
  endtask

  logic [9:0] exp2 [8] = '{10'h004, 10'h0B0, 10'h104, 10'h1C0,
                           10'h204, 10'h2D0, 10'h004, 10'h0B1};
  logic [7:0] exp1 [4] = '{8'h0C, 8'hA1, 8'hA2, 8'hA3};
  logic [9:0] exp3 [5] = '{10'h010, 10'h0E0, 10'h0E1, 10'h0E2, 10'h0E3};

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n   = 1'b0;
    out_ack = 1'b0;
    ch_req  = '0;
    ch_data = '0;
    #2;
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_ch_ack", 32'(ch_ack), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three channels contending, L=1 each: order 0,1,2,0 with one idle gap per packet.
    out_ack = 1'b1;
    q0 = '{8'h04, 8'hB0, 8'h04, 8'hB1};
    q1 = '{8'h04, 8'hC0};
    q2 = '{8'h04, 8'hD0};
    log_q.delete(); log_t.delete();
    n = 0;
    while (log_q.size() < 8 && n < 40) begin tick(); n++; end
    chk("rr_log_size", 32'(log_q.size()), 8);
    for (int i = 0; i < 8; i++)
      if (i < log_q.size()) chk($sformatf("rr_log_%0d", i), 32'(log_q[i]), 32'(exp2[i]));
    if (log_t.size() == 8) begin
      chk("rr_gap_01", 32'(log_t[2] - log_t[1]), 2);
      chk("rr_gap_12", 32'(log_t[4] - log_t[3]), 2);
      chk("rr_gap_20", 32'(log_t[6] - log_t[5]), 2);
    end
    chk("rr_pkt_cnt", 32'(pkt_cnt), 4);

    // Single packet on channel 1, header 0x0C (L=3).
    q1 = '{8'h0C, 8'hA1, 8'hA2, 8'hA3};
    drive();
    #1;
    chk("p1_arb_cycle_out_req", 32'(out_req), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("p1_out_req_%0d", i), 32'(out_req), 1);
      chk($sformatf("p1_out_ch_%0d", i), 32'(out_ch), 1);
      chk($sformatf("p1_ch_ack_%0d", i), 32'(ch_ack), 32'h2);
      chk($sformatf("p1_out_data_%0d", i), 32'(out_data), 32'(exp1[i]));
    end
    tick();
    chk("p1_done_out_req", 32'(out_req), 0);
    chk("p1_pkt_cnt", 32'(pkt_cnt), 5);

    // Two back-to-back L=0 packets on channel 0.
    q0 = '{8'h00, 8'h00};
    tick();
    chk("l0_hdr_out_req", 32'(out_req), 1);
    chk("l0_hdr_ch_ack", 32'(ch_ack), 32'h1);
    chk("l0_hdr_data", 32'(out_data), 0);
    tick();
    chk("l0_idle_out_req", 32'(out_req), 0);
    chk("l0_pkt_cnt_a", 32'(pkt_cnt), 6);
    tick();
    chk("l0_hdr2_out_req", 32'(out_req), 1);
    tick();
    chk("l0_pkt_cnt_b", 32'(pkt_cnt), 7);

    // Channel 0, L=4, sink acks every other cycle.
    q0 = '{8'h10, 8'hE0, 8'hE1, 8'hE2, 8'hE3};
    out_ack = 1'b0;
    ack_toggle = 1'b1;
    log_q.delete(); log_t.delete();
    n = 0;
    while (log_q.size() < 5 && n < 30) begin tick(); n++; end
    ack_toggle = 1'b0;
    out_ack = 1'b1;
    chk("tog_log_size", 32'(log_q.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk($sformatf("tog_log_%0d", i), 32'(log_q[i]), 32'(exp3[i]));
    if (log_t.size() == 5) chk("tog_span", 32'(log_t[4] - log_t[0]), 8);
    chk("tog_pkt_cnt", 32'(pkt_cnt), 8);
    chk("tog_no_abort", 32'(abort_seen), 0);

    // Watchdog: channel 2 sends header 0x14 (L=5) plus two bytes, then goes quiet.
    tick();
    q2 = '{8'h14, 8'hF0, 8'hF1};
    tick();
    chk("wd_hdr_out_ch", 32'(out_ch), 2);
    chk("wd_hdr_data", 32'(out_data), 32'h14);
    tick();
    tick();
    chk("wd_pay_data", 32'(out_data), 32'hF1);
    tick();
    chk("wd_req_low", 32'(out_req), 0);
    chk("wd_abort_c0", 32'(abort), 0);
    q0 = '{8'h00};
    q1 = '{8'h00};
    for (int i = 1; i < 4; i++) begin
      tick();
      chk($sformatf("wd_abort_c%0d", i), 32'(abort), 0);
      chk($sformatf("wd_out_ch_c%0d", i), 32'(out_ch), 2);
      chk($sformatf("wd_out_req_c%0d", i), 32'(out_req), 0);
    end
    tick();
    chk("wd_abort_c4", 32'(abort), 1);
    chk("wd_idle_out_req", 32'(out_req), 0);
    chk("wd_pkt_cnt_same", 32'(pkt_cnt), 8);
    tick();
    chk("wd_abort_c5", 32'(abort), 0);
    chk("wd_next_grant", 32'(out_ch), 0);
    chk("wd_next_out_req", 32'(out_req), 1);
    tick();
    tick();
    tick();
    chk("wd_abort_once", 32'(abort_seen), 1);
    chk("wd_pkt_cnt_after", 32'(pkt_cnt), 10);

    // Reset in the middle of a channel 1 packet.
    q2.delete();
    q1 = '{8'h08, 8'h11, 8'h22};
    tick();
    tick();
    chk("rm_pay_out_req", 32'(out_req), 1);
    chk("rm_pay_ch_ack", 32'(ch_ack), 32'h2);
    rst_n = 1'b0;
    #1;
    chk("rm_async_out_req", 32'(out_req), 0);
    chk("rm_async_ch_ack", 32'(ch_ack), 0);
    chk("rm_async_pkt_cnt", 32'(pkt_cnt), 0);
    tick();
    rst_n = 1'b1;
    q1 = '{8'h04, 8'hAA};
    q0 = '{8'h00};
    drive();
    #1;
    chk("rm_idle_out_req", 32'(out_req), 0);
    tick();
    chk("rm_first_grant", 32'(out_ch), 0);
    chk("rm_first_ack", 32'(ch_ack), 32'h1);
    chk("rm_pkt_cnt", 32'(pkt_cnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
